// File: rtl/ulpi_phy_frontend.sv
// ULPI link-side front end: PHY/core reset sequencing, bus direction and
// turnaround, registered ULPI traffic, and per-channel LED activity stretchers.

module ulpi_led_stretch #(
  parameter int LED_HOLD = 3000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic act_i,
  output logic led_o
);
  localparam int CW = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;

  logic [CW-1:0] cnt;
  logic          act_q;

  // Reload from the registered strobe so the flag covers the first lit cycle
  // and a retrigger never lets the output dip.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      act_q <= 1'b0;
      cnt   <= '0;
    end else begin
      act_q <= act_i;
      if (act_q)           cnt <= CW'(LED_HOLD - 1);
      else if (cnt != '0)  cnt <= cnt - 1'b1;
    end
  end

  assign led_o = act_q | (cnt != '0);
endmodule

module ulpi_phy_frontend #(
  parameter int DATA_W          = 8,
  parameter int PHY_RST_CYCLES  = 64,
  parameter int WAIT_TIMEOUT    = 4096,
  parameter int CORE_RST_CYCLES = 16,
  parameter int NUM_LEDS        = 8,
  parameter int LED_HOLD        = 3000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ulpi_data_i,
  output logic [DATA_W-1:0] ulpi_data_o,
  output logic              ulpi_data_oe_o,
  input  logic              ulpi_dir_i,
  input  logic              ulpi_nxt_i,
  output logic              ulpi_stp_o,
  output logic              phy_rst_no,
  output logic              core_rst_o,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_dir_o,
  output logic              core_nxt_o,
  output logic              core_turnaround_o,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_stp_i,
  input  logic [NUM_LEDS-1:0] activity_i,
  output logic [NUM_LEDS-1:0] leds_o,
  output logic [3:0]        phy_retry_o,
  output logic              ready_o
);
  localparam int MAX_PC  = (PHY_RST_CYCLES > CORE_RST_CYCLES) ? PHY_RST_CYCLES : CORE_RST_CYCLES;
  localparam int CNT_MAX = (WAIT_TIMEOUT > MAX_PC) ? WAIT_TIMEOUT : MAX_PC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] ST_PHY_RST  = 2'd0;
  localparam logic [1:0] ST_WAIT_PHY = 2'd1;
  localparam logic [1:0] ST_CORE_RST = 2'd2;
  localparam logic [1:0] ST_RUN      = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dir_lo_q;
  logic             timeout;
  logic             dir_prev;

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      ST_PHY_RST:
        if (cnt == CNT_W'(PHY_RST_CYCLES - 1)) state_nxt = ST_WAIT_PHY;
      ST_WAIT_PHY:
        // dir low on two consecutive samples wins over a same-cycle timeout
        if (dir_lo_q && !ulpi_dir_i) state_nxt = ST_CORE_RST;
        else if (cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
          state_nxt = ST_PHY_RST;
          timeout   = 1'b1;
        end
      ST_CORE_RST:
        if (cnt == CNT_W'(CORE_RST_CYCLES - 1)) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_PHY_RST;
      cnt         <= '0;
      dir_lo_q    <= 1'b0;
      phy_retry_o <= 4'd0;
    end else begin
      state    <= state_nxt;
      if (state_nxt != state)   cnt <= '0;
      else if (state != ST_RUN) cnt <= cnt + 1'b1;
      dir_lo_q <= (state == ST_WAIT_PHY) && (state_nxt == ST_WAIT_PHY) && !ulpi_dir_i;
      if (timeout && phy_retry_o != 4'hF) phy_retry_o <= phy_retry_o + 4'd1;
    end
  end

  // Pad-side drive follows the next state so stp/data line up with state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ulpi_data_o <= '0;
      ulpi_stp_o  <= 1'b1;
      core_data_o <= '0;
      core_dir_o  <= 1'b0;
      core_nxt_o  <= 1'b0;
      dir_prev    <= 1'b0;
    end else begin
      ulpi_data_o <= (state_nxt == ST_RUN) ? core_data_i : '0;
      ulpi_stp_o  <= (state_nxt == ST_RUN)      ? core_stp_i :
                     (state_nxt == ST_CORE_RST) ? 1'b0 : 1'b1;
      core_data_o <= ulpi_data_i;
      core_dir_o  <= ulpi_dir_i;
      core_nxt_o  <= ulpi_nxt_i;
      dir_prev    <= core_dir_o;
    end
  end

  assign core_turnaround_o = core_dir_o ^ dir_prev;
  assign ulpi_data_oe_o    = (state == ST_RUN) & ~ulpi_dir_i;
  assign phy_rst_no        = (state != ST_PHY_RST);
  assign core_rst_o        = (state != ST_RUN);
  assign ready_o           = (state == ST_RUN);

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    ulpi_led_stretch #(.LED_HOLD(LED_HOLD)) u_led (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .act_i (activity_i[i]),
      .led_o (leds_o[i])
    );
  end
endmodule

// File: tb/tb_ulpi_phy_frontend.sv
// Scoreboard bench for ulpi_phy_frontend: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.

module tb_ulpi_phy_frontend;
  localparam int DW = 8;
  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ulpi_data_i = '0, ulpi_data_o, core_data_o, core_data_i = '0;
  logic          ulpi_data_oe_o, ulpi_dir_i = 1'b0, ulpi_nxt_i = 1'b0, ulpi_stp_o;
  logic          phy_rst_no, core_rst_o, core_dir_o, core_nxt_o, core_turnaround_o;
  logic          core_stp_i = 1'b0, ready_o;
  logic [NL-1:0] activity_i = '0, leds_o;
  logic [3:0]    phy_retry_o;

  ulpi_phy_frontend #(
    .DATA_W(DW), .PHY_RST_CYCLES(4), .WAIT_TIMEOUT(8), .CORE_RST_CYCLES(3),
    .NUM_LEDS(NL), .LED_HOLD(10)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_data_oe_o(ulpi_data_oe_o),
    .ulpi_dir_i(ulpi_dir_i), .ulpi_nxt_i(ulpi_nxt_i), .ulpi_stp_o(ulpi_stp_o),
    .phy_rst_no(phy_rst_no), .core_rst_o(core_rst_o),
    .core_data_o(core_data_o), .core_dir_o(core_dir_o), .core_nxt_o(core_nxt_o),
    .core_turnaround_o(core_turnaround_o),
    .core_data_i(core_data_i), .core_stp_i(core_stp_i),
    .activity_i(activity_i), .leds_o(leds_o),
    .phy_retry_o(phy_retry_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  localparam int S_PHYRST = 0, S_CORERST = 1, S_READY = 2, S_OE = 3, S_STP = 4,
                 S_DATA = 5, S_CDATA = 6, S_CDIR = 7, S_TURN = 8, S_LEDS = 9,
                 S_RETRY = 10, S_NXT = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] getsig(int id);
    case (id)
      S_PHYRST:  return 32'(phy_rst_no);
      S_CORERST: return 32'(core_rst_o);
      S_READY:   return 32'(ready_o);
      S_OE:      return 32'(ulpi_data_oe_o);
      S_STP:     return 32'(ulpi_stp_o);
      S_DATA:    return 32'(ulpi_data_o);
      S_CDATA:   return 32'(core_data_o);
      S_CDIR:    return 32'(core_dir_o);
      S_TURN:    return 32'(core_turnaround_o);
      S_LEDS:    return 32'(leds_o);
      S_RETRY:   return 32'(phy_retry_o);
      default:   return 32'(core_nxt_o);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, flag any that slipped.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] got;
        got = getsig(sb[i].sig);
        n_cmp++;
        if (got !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].nm, cyc, got, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation for cyc %0d never sampled", sb[i].nm, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic exp(int dc, int sig, logic [31:0] v, string nm);
    sb.push_back('{cyc + dc, sig, v, nm});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected bring-up with dir low: 4 PHY_RST, 2 WAIT_PHY, 3 CORE_RST, then RUN.
  task automatic exp_bringup(string tag);
    exp(3, S_PHYRST, 0, {tag, "_phyrst_last_low"});
    exp(4, S_PHYRST, 1, {tag, "_phyrst_high"});
    exp(5, S_STP, 1, {tag, "_stp_wait"});
    exp(6, S_STP, 0, {tag, "_stp_corerst"});
    exp(8, S_CORERST, 1, {tag, "_corerst_last"});
    exp(9, S_CORERST, 0, {tag, "_corerst_fall"});
    exp(8, S_READY, 0, {tag, "_ready_early"});
    exp(9, S_READY, 1, {tag, "_ready"});
    exp(9, S_OE, 1, {tag, "_oe_run"});
  endtask

  initial begin
    int n;
    // reset state
    ulpi_data_i = 8'h77;
    tick(3);
    exp(0, S_PHYRST, 0, "rst_phyrst");
    exp(0, S_CORERST, 1, "rst_corerst");
    exp(0, S_STP, 1, "rst_stp");
    exp(0, S_DATA, 0, "rst_data");
    exp(0, S_CDATA, 0, "rst_cdata");
    exp(0, S_READY, 0, "rst_ready");
    exp(0, S_LEDS, 0, "rst_leds");
    exp(0, S_RETRY, 0, "rst_retry");
    exp(0, S_OE, 0, "rst_oe");
    tick(1);

    rst_n = 1'b1;
    exp_bringup("up1");
    exp(1, S_CDATA, 8'h77, "cdata_77");
    exp(9, S_RETRY, 0, "up1_retry");
    tick(9);

    // RUN: transmit and receive registers
    core_data_i = 8'hA5; core_stp_i = 1'b1; ulpi_data_i = 8'h3C; ulpi_nxt_i = 1'b1;
    exp(1, S_DATA, 8'hA5, "tx_data_a5");
    exp(1, S_STP, 1, "tx_stp_1");
    exp(1, S_CDATA, 8'h3C, "rx_data_3c");
    exp(1, S_NXT, 1, "rx_nxt_1");
    tick(1);
    core_data_i = 8'h5A; core_stp_i = 1'b0; ulpi_nxt_i = 1'b0;
    exp(1, S_DATA, 8'h5A, "tx_data_5a");
    exp(1, S_STP, 0, "tx_stp_0");
    exp(1, S_NXT, 0, "rx_nxt_0");
    tick(1);

    // turnaround, both edges and per-cycle toggling
    ulpi_dir_i = 1'b1;
    exp(0, S_OE, 0, "oe_drop_same_cycle");
    exp(1, S_CDIR, 1, "cdir_rise");
    exp(1, S_TURN, 1, "turn_rise");
    exp(2, S_TURN, 0, "turn_rise_one_cycle");
    exp(2, S_CDIR, 1, "cdir_hold");
    tick(2);
    ulpi_dir_i = 1'b0;
    exp(0, S_OE, 1, "oe_restore");
    exp(1, S_CDIR, 0, "cdir_fall");
    exp(1, S_TURN, 1, "turn_fall");
    exp(2, S_TURN, 0, "turn_fall_one_cycle");
    tick(2);
    ulpi_dir_i = 1'b1;
    exp(1, S_TURN, 1, "turn_toggle_a");
    tick(1);
    ulpi_dir_i = 1'b0;
    exp(1, S_TURN, 1, "turn_toggle_b");
    exp(2, S_TURN, 0, "turn_toggle_end");
    tick(3);

    // LED single pulse on channel 2
    activity_i = 8'h04;
    exp(0, S_LEDS, 8'h00, "led_before");
    exp(1, S_LEDS, 8'h04, "led_first");
    exp(10, S_LEDS, 8'h04, "led_last");
    exp(11, S_LEDS, 8'h00, "led_off");
    tick(1);
    activity_i = '0;
    tick(13);

    // LED retrigger at t0+5 extends to t0+15
    activity_i = 8'h04;
    exp(6, S_LEDS, 8'h04, "led_retrig_no_glitch_a");
    exp(7, S_LEDS, 8'h04, "led_retrig_no_glitch_b");
    exp(15, S_LEDS, 8'h04, "led_retrig_last");
    exp(16, S_LEDS, 8'h00, "led_retrig_off");
    tick(1);
    activity_i = '0;
    tick(4);
    activity_i = 8'h04;
    tick(1);
    activity_i = '0;
    tick(13);

    // LED held continuously on channel 7
    activity_i = 8'h80;
    exp(20, S_LEDS, 8'h80, "led_held_on");
    exp(29, S_LEDS, 8'h80, "led_held_tail");
    exp(30, S_LEDS, 8'h00, "led_held_off");
    tick(20);
    activity_i = '0;
    tick(12);

    // async reset mid-RUN with dir low
    rst_n = 1'b0;
    exp(0, S_OE, 0, "arst_oe");
    exp(0, S_PHYRST, 0, "arst_phyrst");
    exp(0, S_CORERST, 1, "arst_corerst");
    exp(0, S_READY, 0, "arst_ready");
    tick(2);

    // timeout retries with dir held high
    ulpi_dir_i = 1'b1;
    rst_n = 1'b1;
    exp(11, S_PHYRST, 1, "to_wait_high");
    exp(11, S_RETRY, 0, "to_retry0");
    exp(12, S_PHYRST, 0, "to_repulse");
    exp(12, S_RETRY, 1, "to_retry1");
    exp(15, S_PHYRST, 0, "to_repulse_last");
    exp(16, S_PHYRST, 1, "to_repulse_end");
    exp(24, S_RETRY, 2, "to_retry2");
    exp(180, S_RETRY, 15, "to_retry15");
    exp(240, S_RETRY, 15, "to_retry_sat");
    exp(240, S_READY, 0, "to_not_ready");
    tick(245);
    ulpi_dir_i = 1'b0;
    exp(4, S_READY, 0, "to_recover_early");
    exp(5, S_READY, 1, "to_recover_run");
    exp(5, S_RETRY, 15, "to_recover_retry");
    tick(8);

    // async reset again, then full sequence from PHY_RST with retry cleared
    rst_n = 1'b0;
    exp(0, S_OE, 0, "arst2_oe");
    exp(0, S_RETRY, 0, "arst2_retry");
    exp(0, S_STP, 1, "arst2_stp");
    tick(2);
    rst_n = 1'b1;
    exp_bringup("up2");
    exp(9, S_RETRY, 0, "up2_retry");
    tick(10);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      tick(1);
      n++;
    end
    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cyc %0d left pending", sb[i].nm, sb[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ulpi_phy_frontend.md
Name: ulpi_phy_frontend

Overview:
Parametrised ULPI link-side front end that sits between the board pins and the core. It sequences PHY reset and core reset. It owns data-bus direction and turnaround, registers all ULPI traffic to and from the core, and drives N LED activity stretchers. This block replaces ad-hoc reset flops and per-board buffer glue, so board wrappers reduce to pad primitives plus this block.

Parameters:
DATA_W, 8, ULPI data bus width
PHY_RST_CYCLES, 64, cycles phy_rst_no held low per attempt (>=2)
WAIT_TIMEOUT, 4096, max cycles waiting for PHY dir low before retrying reset
CORE_RST_CYCLES, 16, cycles core_rst_o held after PHY ready (>=1)
NUM_LEDS, 8, activity channels / LED outputs
LED_HOLD, 3000000, stretch length in cycles per activity pulse

Ports:
clk_i  in  1  ULPI 60MHz clock; single clock domain
rst_i  in  1  asynchronous, active-low reset
ulpi_data_i  in  DATA_W  pad input data
ulpi_data_o  out  DATA_W  pad output data
ulpi_data_oe_o  out  1  pad output enable; 1 = link drives bus
ulpi_dir_i  in  1  PHY dir
ulpi_nxt_i  in  1  PHY nxt
ulpi_stp_o  out  1  link stp
phy_rst_no  out  1  PHY reset, active low
core_rst_o  out  1  synchronous active-high reset to core
core_data_o  out  DATA_W  registered ulpi_data_i
core_dir_o  out  1  registered ulpi_dir_i
core_nxt_o  out  1  registered ulpi_nxt_i
core_turnaround_o  out  1  high one cycle after any dir change
core_data_i  in  DATA_W  data from core
core_stp_i  in  1  stp from core
activity_i  in  NUM_LEDS  single-cycle activity strobes
leds_o  out  NUM_LEDS  stretched LED drives, active high
phy_retry_o  out  4  saturating count of PHY reset retries
ready_o  out  1  high in RUN

Behaviour:
- Reset (rst_i=0), async, all registers cleared: state=PHY_RST, phy_rst_no=0, core_rst_o=1, ulpi_stp_o=1, ulpi_data_o=0, core_* outputs=0, leds_o=0, phy_retry_o=0, ready_o=0.
- FSM:
  - PHY_RST: phy_rst_no=0 for exactly PHY_RST_CYCLES cycles from counter load, then go to WAIT_PHY.
  - WAIT_PHY: phy_rst_no=1, stp=1. Sampled ulpi_dir_i==0 for 2 consecutive cycles -> CORE_RST. Counter reaching WAIT_TIMEOUT first -> PHY_RST and phy_retry_o+1, saturating at 15.
  - CORE_RST: core_rst_o=1 for CORE_RST_CYCLES cycles, stp=0 -> RUN.
  - RUN: core_rst_o=0, ready_o=1. Stays in RUN until rst_i asserts; no exit otherwise.
  - One shared counter; it is reloaded on every state entry.
- ulpi_data_oe_o = (state==RUN) & ~ulpi_dir_i, combinational from the pin. The link releases the bus in the same cycle dir rises; no contention cycle.
- RUN outputs: ulpi_data_o <= core_data_i, ulpi_stp_o <= core_stp_i, both registered with 1-cycle latency.
- Outside RUN: ulpi_data_o forced to 0. ulpi_stp_o is 1 in PHY_RST and WAIT_PHY, 0 in CORE_RST.
- Receive path, all states: core_data_o, core_dir_o, core_nxt_o are the pins registered, 1-cycle latency.
- core_turnaround_o = core_dir_o XOR previous core_dir_o. Both edges flag, including a dir toggle every cycle.
- LED channel i: an activity_i[i] pulse loads its counter with LED_HOLD-1. While the counter is nonzero it decrements each cycle. leds_o[i] = (counter!=0) | activity_i-registered flag.
  - A retrigger while lit reloads the counter with no glitch low.
  - A pulse held high continuously keeps the LED lit.
  - Counter width = clog2(LED_HOLD).
- Async reset asserted mid-RUN: oe drops immediately (state clears). Release restarts the full sequence from PHY_RST.

Test Plan:
- PHY_RST_CYCLES=4, CORE_RST_CYCLES=3, dir=0 after rst_i release -> phy_rst_no low exactly 4 cycles. core_rst_o falls 4+2+3 cycles later. ready_o=1 next.
- WAIT_TIMEOUT=8, dir held 1 -> phy_rst_no re-pulses every 4+8 cycles. phy_retry_o counts 1,2,...; after 20 attempts it reads 15. Drop dir -> reaches RUN.
- In RUN, ulpi_dir_i 0->1 -> ulpi_data_oe_o falls the same cycle. core_dir_o=1 and core_turnaround_o=1 next cycle only. 1->0 -> turnaround pulses again.
- In RUN, core_data_i=0xA5 with core_stp_i=1 -> ulpi_data_o=0xA5 and ulpi_stp_o=1 one cycle later. Pin data 0x3C -> core_data_o=0x3C one cycle later.
- LED_HOLD=10: pulse activity_i[2] at t0 -> leds_o[2] high t0+1..t0+10. A retrigger at t0+5 extends it to t0+15. Other LEDs stay 0.
- rst_i low mid-RUN with dir=0 -> ulpi_data_oe_o=0, phy_rst_no=0, core_rst_o=1 asynchronously. On release the sequence repeats; phy_retry_o=0.
